// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state
// encodings, exception cause codes and the access-legality helpers.
// Used by load_store_unit and lsu_align.
package load_store_unit_pkg;

  // funct3 access codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // exc_cause codes
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b10;

  // Loads only define 000/001/010/100/101; stores only the low half of funct3.
  function automatic logic is_illegal_width(input logic [2:0] funct3, input logic is_store);
    if (is_store) return funct3[2];
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  // funct3[1:0] gives the access size: 00 byte, 01 half, otherwise word.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and replicated store data, plus
// load byte/half extraction with sign or zero extension.
// Purely combinational; store and load sides have independent inputs.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_rs2,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: lanes follow the offset, data is replicated so any lane carries it
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_rs2;
    case (st_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << st_off;
        st_wdata = {4{st_rs2[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {st_off[1], 1'b0};
        st_wdata = {2{st_rs2[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed byte/half, then extend per funct3
  always_comb begin
    byte_sel = ld_rdata[7:0];
    case (ld_off)
      2'd1:    byte_sel = ld_rdata[15:8];
      2'd2:    byte_sel = ld_rdata[23:16];
      2'd3:    byte_sel = ld_rdata[31:24];
      default: ;
    endcase
    half_sel = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_funct3)
      F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  ld_data = {24'd0, byte_sel};
      F3_LHU:  ld_data = {16'd0, half_sel};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request/ack data-memory transaction per accepted op.
// Latency: store 2 cycles, load 3 cycles with zero-wait memory; exception 1 cycle.
// Backpressure: ex_ready low outside IDLE; mem_req held until mem_ack; wb has none.
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_is_store,
  input  logic [4:0]  ex_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_cause,
  output logic [31:0] exc_addr
);

  logic [1:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        req_q, req_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_valid_q, exc_valid_d;
  logic [1:0]  exc_cause_q, exc_cause_d;
  logic [31:0] exc_addr_q, exc_addr_d;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  lsu_align u_align (
    .st_funct3 (ex_funct3),
    .st_off    (ex_addr[1:0]),
    .st_rs2    (ex_wdata),
    .st_be     (st_be),
    .st_wdata  (st_wdata),
    .ld_funct3 (funct3_q),
    .ld_off    (addr_q[1:0]),
    .ld_rdata  (mem_rdata),
    .ld_data   (ld_data)
  );

  // Next-state and output-register logic for the IDLE/REQ/RESP sequencer
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    req_d       = req_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;
    exc_addr_d  = exc_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid) begin
          if (is_illegal_width(ex_funct3, ex_is_store)) begin
            exc_valid_d = 1'b1;
            exc_cause_d = EXC_ILLEGAL;
            exc_addr_d  = ex_addr;
`ifdef LSU_MISALIGN_TRAP_EN
          end else if (is_misaligned(ex_funct3, ex_addr[1:0])) begin
            exc_valid_d = 1'b1;
            exc_cause_d = EXC_MISALIGN;
            exc_addr_d  = ex_addr;
`endif
          end else begin
            addr_d   = ex_addr;
            funct3_d = ex_funct3;
            rd_d     = ex_rd;
            we_d     = ex_is_store;
            wdata_d  = st_wdata;
            be_d     = ex_is_store ? st_be : 4'b0000;
            req_d    = 1'b1;
            state_d  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          req_d = 1'b0;
          if (we_q) begin
            state_d = ST_IDLE;
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = ld_data;
            state_d    = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      req_q       <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_q       <= req_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign ex_ready  = (state_q == ST_IDLE);
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign exc_valid = exc_valid_q;
  assign exc_cause = exc_cause_q;
  assign exc_addr  = exc_addr_q;

endmodule
